tick_to_level_generator: RTL and testbench

//   Inverse of the dual edge detector: rebuilds a level waveform from a stream of single-cycle edge ticks.

---
 rtl/edge_pkg.sv | 30 +++
 rtl/tick_to_level_generator.sv | 176 +++++++++++++++++
 tb/tb_tick_to_level_generator.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/edge_pkg.sv
// -----------------------------------------------------------------------------
// edge_pkg
//   Shared definitions for the tick/level conversion blocks.
//
//   tlg_state_t   : state of the tick-to-level generator
//                   IDLE - no hold in progress, the next tick toggles at once
//                   HOLD - the current level is being held for its minimum time
//   clog2_min1()  : ceil(log2(value)) but never below 1. Use it to size counters
//                   that must still exist when the count range collapses to one
//                   value (e.g. a hold of a single clock).
// -----------------------------------------------------------------------------
package edge_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } tlg_state_t;

  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage : edge_pkg

// File: rtl/tick_to_level_generator.sv
// -----------------------------------------------------------------------------
// tick_to_level_generator
//   Rebuilds a level waveform from a stream of single-cycle edge ticks. Each
//   accepted tick toggles 'level'. Every level value is held for at least
//   MIN_HOLD clocks so that a downstream edge detector or slow consumer sees
//   every edge. Ticks arriving while a level is being held are queued in a
//   saturating pending counter; a tick that finds the queue full is dropped
//   and recorded in the sticky 'overflow' flag.
//
// Parameters
//   MIN_HOLD     minimum clocks between consecutive toggles (>= 1)
//   MAX_PENDING  maximum queued ticks (>= 1)
//   INIT_LEVEL   value of 'level' out of reset
//
// Ports
//   clk       in   1   system clock, all logic on the rising edge
//   reset     in   1   synchronous active-high reset, highest priority
//   tick      in   1   edge request, one request per high cycle
//   clear     in   1   flush the pending queue and clear 'overflow'; the
//                      same-cycle tick is ignored, the running hold continues
//   level     out  1   reconstructed level (registered)
//   busy      out  1   holding a level or ticks still queued
//   pending   out  PW  number of queued ticks, PW = $clog2(MAX_PENDING+1)
//   overflow  out  1   sticky: at least one tick was dropped
//
// Timing
//   A tick sampled at edge n changes 'level' right after edge n. After a
//   toggle the hold counter is loaded with MIN_HOLD-1 and counts down once
//   per clock; the hold expires when the counter reads zero in HOLD, which
//   puts consecutive toggles exactly MIN_HOLD or more edges apart.
// -----------------------------------------------------------------------------
module tick_to_level_generator
  import edge_pkg::*;
#(
  parameter int   MIN_HOLD    = 4,
  parameter int   MAX_PENDING = 3,
  parameter logic INIT_LEVEL  = 1'b0,
  localparam int  PW          = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          clear,
  output logic          level,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  // Hold counter width; stays 1 bit wide when MIN_HOLD is 1.
  localparam int HW = clog2_min1(MIN_HOLD);

  localparam logic [HW-1:0] HOLD_RELOAD = HW'(MIN_HOLD - 1);
  localparam logic [HW-1:0] HOLD_ZERO   = {HW{1'b0}};
  localparam logic [HW-1:0] HOLD_ONE    = HW'(1);
  localparam logic [PW-1:0] PEND_MAX    = PW'(MAX_PENDING);
  localparam logic [PW-1:0] PEND_ZERO   = {PW{1'b0}};
  localparam logic [PW-1:0] PEND_ONE    = PW'(1);

  // State registers.
  tlg_state_t    state_r;
  logic          level_r;
  logic [HW-1:0] hold_cnt_r;
  logic [PW-1:0] pending_r;
  logic          overflow_r;

  // Next-state values.
  tlg_state_t    state_n;
  logic          level_n;
  logic [HW-1:0] hold_cnt_n;
  logic [PW-1:0] pending_n;
  logic          overflow_n;

  // Qualified inputs: clear masks the tick and makes the queue look empty
  // for this cycle's expiry decision.
  logic          tick_eff_s;
  logic [PW-1:0] pend_eff_s;
  logic          expiry_s;

  assign tick_eff_s = tick & ~clear;
  assign pend_eff_s = clear ? PEND_ZERO : pending_r;
  assign expiry_s   = (state_r == HOLD) && (hold_cnt_r == HOLD_ZERO);

  // Next-state logic: toggle scheduling, hold countdown and queue management.
  always_comb begin
    state_n    = state_r;
    level_n    = level_r;
    hold_cnt_n = hold_cnt_r;
    pending_n  = pending_r;
    overflow_n = overflow_r;

    if (clear) begin
      pending_n  = PEND_ZERO;
      overflow_n = 1'b0;
    end else begin
      pending_n  = pending_r;
      overflow_n = overflow_r;
    end

    case (state_r)
      IDLE: begin
        if (tick_eff_s) begin
          level_n    = ~level_r;
          hold_cnt_n = HOLD_RELOAD;
          state_n    = HOLD;
        end else begin
          state_n    = IDLE;
        end
      end

      HOLD: begin
        if (!expiry_s) begin
          hold_cnt_n = hold_cnt_r - HOLD_ONE;
          if (tick_eff_s) begin
            if (pending_r < PEND_MAX) begin
              pending_n  = pending_r + PEND_ONE;
            end else begin
              // Queue full: the tick is lost and the loss is remembered.
              overflow_n = 1'b1;
            end
          end else begin
            pending_n = pend_eff_s;
          end
        end else if (pend_eff_s != PEND_ZERO) begin
          // Serve one queued tick. A tick arriving now takes its place, so
          // the queue depth only drops when no new tick comes in.
          level_n    = ~level_r;
          hold_cnt_n = HOLD_RELOAD;
          state_n    = HOLD;
          if (tick_eff_s) begin
            pending_n = pending_r;
          end else begin
            pending_n = pending_r - PEND_ONE;
          end
        end else if (tick_eff_s) begin
          level_n    = ~level_r;
          hold_cnt_n = HOLD_RELOAD;
          state_n    = HOLD;
        end else begin
          state_n    = IDLE;
        end
      end

      default: begin
        state_n    = IDLE;
        level_n    = INIT_LEVEL;
        hold_cnt_n = HOLD_ZERO;
        pending_n  = PEND_ZERO;
        overflow_n = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset; reset aborts any hold in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      level_r    <= INIT_LEVEL;
      hold_cnt_r <= HOLD_ZERO;
      pending_r  <= PEND_ZERO;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      level_r    <= level_n;
      hold_cnt_r <= hold_cnt_n;
      pending_r  <= pending_n;
      overflow_r <= overflow_n;
    end
  end

  assign level    = level_r;
  assign pending  = pending_r;
  assign overflow = overflow_r;
  assign busy     = (state_r == HOLD) || (pending_r != PEND_ZERO);

endmodule : tick_to_level_generator

// File: tb/tb_tick_to_level_generator.sv
// -----------------------------------------------------------------------------
// tb_tick_to_level_generator
//   Two instances share one stimulus stream: u_dut_a with the default
//   parameters (MIN_HOLD=4) and u_dut_b with MIN_HOLD=1. For every driven
//   cycle a timestamp-based reference model computes the expected outputs of
//   both instances and pushes them to a scoreboard queue; after the clock
//   edge the entries are popped and compared. Fixed expectations from the
//   reference scenarios are checked on top of that, and u_dut_b's level is
//   looped through a dual edge detector to count the edges it rebuilds.
// -----------------------------------------------------------------------------
module tb_tick_to_level_generator;

  localparam int MAXP = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       clear;
  logic       level_a, busy_a, overflow_a;
  logic [1:0] pending_a;
  logic       level_b, busy_b, overflow_b;
  logic [1:0] pending_b;

  always #5 clk = ~clk;

  tick_to_level_generator #(
    .MIN_HOLD(4), .MAX_PENDING(3), .INIT_LEVEL(1'b0)
  ) u_dut_a (
    .clk(clk), .reset(reset), .tick(tick), .clear(clear),
    .level(level_a), .busy(busy_a), .pending(pending_a), .overflow(overflow_a)
  );

  tick_to_level_generator #(
    .MIN_HOLD(1), .MAX_PENDING(3), .INIT_LEVEL(1'b0)
  ) u_dut_b (
    .clk(clk), .reset(reset), .tick(tick), .clear(clear),
    .level(level_b), .busy(busy_b), .pending(pending_b), .overflow(overflow_b)
  );

  // Dual edge detector fed by u_dut_b's level.
  logic lvl_b_d;
  logic ed_tick;
  always @(posedge clk) begin
    if (reset) lvl_b_d <= 1'b0;
    else       lvl_b_d <= level_b;
  end
  assign ed_tick = level_b ^ lvl_b_d;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;
  int ed_count = 0;

  typedef struct {
    int level;
    int busy;
    int pending;
    int overflow;
  } exp_t;
  exp_t sb_q[$];

  // Reference model state per unit: level, queue depth, sticky error and the
  // earliest edge index at which the next toggle may happen.
  int m_level[2];
  int m_pend[2];
  int m_ovf[2];
  int m_next_ok[2];

  int s2_p[6] = '{2, 1, 1, 1, 1, 0};

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (edge %0d)", tag, got, exp, cyc_n);
    end
  endtask

  task automatic model_step(input int u, input int hold, input logic t, input logic c,
                            input logic r, input int n, output exp_t e);
    int   demand;
    logic t_eff;
    if (r) begin
      m_level[u]   = 0;
      m_pend[u]    = 0;
      m_ovf[u]     = 0;
      m_next_ok[u] = 0;
    end else begin
      t_eff = t && !c;
      if (c) begin
        m_pend[u] = 0;
        m_ovf[u]  = 0;
      end
      demand = m_pend[u] + (t_eff ? 1 : 0);
      if (n >= m_next_ok[u]) begin
        if (demand > 0) begin
          m_level[u]   = 1 - m_level[u];
          m_next_ok[u] = n + hold;
          m_pend[u]    = demand - 1;
        end
      end else if (t_eff) begin
        if (m_pend[u] < MAXP) m_pend[u] = m_pend[u] + 1;
        else                  m_ovf[u]  = 1;
      end
    end
    e.level    = m_level[u];
    e.busy     = ((n < m_next_ok[u]) || (m_pend[u] != 0)) ? 1 : 0;
    e.pending  = m_pend[u];
    e.overflow = m_ovf[u];
  endtask

  // Drive one cycle of stimulus, predict, let the edge happen, then compare.
  task automatic step(input logic t, input logic c, input logic r);
    exp_t e;
    tick  = t;
    clear = c;
    reset = r;
    model_step(0, 4, t, c, r, cyc_n, e);
    sb_q.push_back(e);
    model_step(1, 1, t, c, r, cyc_n, e);
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
    if (ed_tick) ed_count++;
    e = sb_q.pop_front();
    check_value("a_level",    level_a,    e.level);
    check_value("a_busy",     busy_a,     e.busy);
    check_value("a_pending",  pending_a,  e.pending);
    check_value("a_overflow", overflow_a, e.overflow);
    e = sb_q.pop_front();
    check_value("b_level",    level_b,    e.level);
    check_value("b_busy",     busy_b,     e.busy);
    check_value("b_pending",  pending_b,  e.pending);
    check_value("b_overflow", overflow_b, e.overflow);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1);
    check_value("rst_level", level_a, 0);
    check_value("rst_busy", busy_a, 0);
    check_value("rst_pending", pending_a, 0);
    check_value("rst_overflow", overflow_a, 0);
    idle(2);
  endtask

  initial begin
    tick  = 1'b0;
    clear = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    // 1: single tick
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    check_value("s1_level_e10", level_a, 1);
    check_value("s1_busy_e10", busy_a, 1);
    idle(3);
    check_value("s1_busy_e13", busy_a, 1);
    idle(1);
    check_value("s1_busy_e14", busy_a, 0);
    check_value("s1_level_end", level_a, 1);

    // 2: three back-to-back ticks
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_value("s2_pend_e11", pending_a, 1);
    step(1'b1, 1'b0, 1'b0);
    check_value("s2_pend_e12", pending_a, 2);
    for (int i = 0; i < 6; i++) begin
      idle(1);
      check_value("s2_pend_seq", pending_a, s2_p[i]);
    end
    idle(4);
    check_value("s2_level_end", level_a, 1);
    check_value("s2_busy_end", busy_a, 0);
    check_value("s2_ovf_end", overflow_a, 0);

    // 3 and 4: six ticks, overflow, then clear once everything drained
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (i == 3) check_value("s3_pend_e13", pending_a, 3);
      if (i == 4) check_value("s3_pend_e14", pending_a, 3);
      if (i == 5) check_value("s3_ovf_e15", overflow_a, 1);
    end
    idle(14);
    check_value("s3_level_end", level_a, 1);
    check_value("s3_ovf_sticky", overflow_a, 1);
    step(1'b0, 1'b1, 1'b0);
    check_value("s4_pend_clr", pending_a, 0);
    check_value("s4_ovf_clr", overflow_a, 0);
    check_value("s4_level", level_a, 1);
    idle(1);
    check_value("s4_idle", busy_a, 0);

    // 4b: clear mid-hold with a full queue; the hold still runs out
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 1'b1, 1'b0);
    check_value("s4b_pend_clr", pending_a, 0);
    check_value("s4b_ovf_clr", overflow_a, 0);
    check_value("s4b_busy_hold", busy_a, 1);
    idle(1);
    check_value("s4b_busy_exp", busy_a, 0);
    check_value("s4b_level", level_a, 0);

    // 5: reset mid-hold
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check_value("s5_level", level_a, 0);
    check_value("s5_pend", pending_a, 0);
    check_value("s5_busy", busy_a, 0);
    idle(8);
    check_value("s5_level_end", level_a, 0);

    // 6: MIN_HOLD=1 follows a tick every cycle, loopback edge count
    do_reset();
    ed_count = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check_value("s6_level", level_b, (i + 1) % 2);
      check_value("s6_pend", pending_b, 0);
    end
    check_value("s6_edges", ed_count, 8);
    check_value("s6_ovf", overflow_b, 0);
    idle(2);
    check_value("s6_edges_quiet", ed_count, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_tick_to_level_generator
